// File: rtl/data_mem_port_if.sv
// Signal bundle of one core's data-memory port: core request/response,
// memory address/data/strobes and the shared-region arbiter handshake.
interface data_mem_port_if #(
    parameter int TAM = 16
);
    logic           reqValid;
    logic           reqWrite;
    logic [TAM-1:0] reqAddr;
    logic [TAM-1:0] reqData;
    logic           reqReady;
    logic           respValid;
    logic [TAM-1:0] respData;
    logic           respErr;
    logic [TAM-1:0] dataADDR;
    logic [TAM-1:0] dataIN;
    logic           dataLoad;
    logic           dataWrite;
    logic [TAM-1:0] dataOUT;
    logic           sharedReq;
    logic           sharedGrant;

    modport master (
        output reqValid, reqWrite, reqAddr, reqData,
        output dataOUT, sharedGrant,
        input  reqReady, respValid, respData, respErr,
        input  dataADDR, dataIN, dataLoad, dataWrite, sharedReq
    );

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqData,
        input  dataOUT, sharedGrant,
        output reqReady, respValid, respData, respErr,
        output dataADDR, dataIN, dataLoad, dataWrite, sharedReq
    );
endinterface

// File: rtl/data_mem_port.sv
// Per-core data-memory initiator: one request in flight, shared-region
// accesses wait for the arbiter grant with a bounded timeout.
module data_mem_port #(
    parameter int TAM     = 16,
    parameter int Lmem    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_port_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt;
    logic           r_err;
    logic           w_err;
    logic [TAM-1:0] r_addr;
    logic [TAM-1:0] r_data;
    logic           r_write;

    logic           r_respValid;
    logic           r_respErr;
    logic [TAM-1:0] r_respData;
    logic [TAM-1:0] r_dataADDR;
    logic [TAM-1:0] r_dataIN;
    logic           r_dataLoad;
    logic           r_dataWrite;
    logic           r_sharedReq;

    logic           w_oor;
    logic           w_accept;
    logic [TAM-1:0] w_addr;
    logic [TAM-1:0] w_data;
    logic           w_write;
    logic           w_respValid;
    logic           w_respErr;
    logic [TAM-1:0] w_respData;
    logic [TAM-1:0] w_dataADDR;
    logic [TAM-1:0] w_dataIN;
    logic           w_dataLoad;
    logic           w_dataWrite;
    logic           w_sharedReq;

    assign w_oor    = |bus.reqAddr[TAM-1:Lmem+1];
    assign w_accept = (r_state == IDLE) && bus.reqValid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_write     <= 1'b0;
            r_respValid <= 1'b0;
            r_respErr   <= 1'b0;
            r_respData  <= '0;
            r_dataADDR  <= '0;
            r_dataIN    <= '0;
            r_dataLoad  <= 1'b0;
            r_dataWrite <= 1'b0;
            r_sharedReq <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt;
            r_err       <= w_err;
            if (w_accept) begin
                r_addr  <= bus.reqAddr;
                r_data  <= bus.reqData;
                r_write <= bus.reqWrite;
            end
            r_respValid <= w_respValid;
            r_respErr   <= w_respErr;
            r_respData  <= w_respData;
            r_dataADDR  <= w_dataADDR;
            r_dataIN    <= w_dataIN;
            r_dataLoad  <= w_dataLoad;
            r_dataWrite <= w_dataWrite;
            r_sharedReq <= w_sharedReq;
        end
    end

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_err  = r_err;
        unique case (r_state)
            IDLE: begin
                if (bus.reqValid) begin
                    w_err = 1'b0;
                    w_cnt = '0;
                    if (w_oor) begin
                        w_next = RESP;
                        w_err  = 1'b1;
                    end else if (bus.reqAddr[Lmem]) begin
                        w_next = WAIT_GNT;
                    end else begin
                        w_next = ACCESS;
                    end
                end
            end
            WAIT_GNT: begin
                if (r_cnt != 4'hF) w_cnt = r_cnt + 4'd1;
                // A grant on the last allowed cycle still wins
                if (bus.sharedGrant) begin
                    w_next = ACCESS;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = RESP;
                    w_err  = 1'b1;
                end
            end
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_addr  = r_addr;
        w_data  = r_data;
        w_write = r_write;
        if (r_state == IDLE) begin
            w_addr  = bus.reqAddr;
            w_data  = bus.reqData;
            w_write = bus.reqWrite;
        end
        w_respValid = (w_next == RESP);
        w_respErr   = w_respValid & w_err;
        w_respData  = '0;
        // Memory drives dataOUT mid-ACCESS; capture it at the edge leaving ACCESS
        if (w_respValid && (r_state == ACCESS) && !r_write) begin
            w_respData = bus.dataOUT;
        end
        w_dataLoad  = (w_next == ACCESS) & ~w_write;
        w_dataWrite = (w_next == ACCESS) & w_write;
        w_dataADDR  = r_dataADDR;
        w_dataIN    = r_dataIN;
        if (w_next == ACCESS) begin
            w_dataADDR = w_addr;
            w_dataIN   = w_data;
        end
        w_sharedReq = (w_next == WAIT_GNT) |
                      ((w_next == ACCESS) & (r_state == WAIT_GNT));
    end

    assign bus.reqReady  = (r_state == IDLE);
    assign bus.respValid = r_respValid;
    assign bus.respErr   = r_respErr;
    assign bus.respData  = r_respData;
    assign bus.dataADDR  = r_dataADDR;
    assign bus.dataIN    = r_dataIN;
    assign bus.dataLoad  = r_dataLoad;
    assign bus.dataWrite = r_dataWrite;
    assign bus.sharedReq = r_sharedReq;
endmodule

// File: tb/tb_data_mem_port.sv
// Bench for data_mem_port: memory model, response scoreboard and
// per-scenario tasks.
module tb_data_mem_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   n_load      = 0;
    int   n_write     = 0;
    int   n_overlap   = 0;
    int   n_resp      = 0;
    logic [15:0] last_waddr = '0;
    logic [15:0] last_wdata = '0;
    logic        last_shr   = 1'b0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    logic [15:0] mem [0:1023];

    data_mem_port_if #(.TAM(16)) bus ();

    data_mem_port #(
        .TAM(16),
        .Lmem(8),
        .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (bus.dataLoad) bus.dataOUT <= mem[bus.dataADDR[9:0]];
    always @(posedge clk)
        if (bus.dataWrite) mem[bus.dataADDR[9:0]] <= bus.dataIN;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (bus.dataLoad) n_load++;
        if (bus.dataWrite) begin
            n_write++;
            last_waddr = bus.dataADDR;
            last_wdata = bus.dataIN;
        end
        if (bus.dataLoad && bus.dataWrite) n_overlap++;
        if (bus.dataLoad || bus.dataWrite) last_shr = bus.sharedReq;
        if (bus.respValid) begin
            n_resp++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected: respValid at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc || bus.respErr !== e.err || bus.respData !== e.data) begin
                    miscompares++;
                    $display("FAIL resp: cycle=%0d err=%b data=%h, required cycle=%0d err=%b data=%h",
                             cyc, bus.respErr, bus.respData, e.cyc, e.err, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int lat, input logic e, input logic [15:0] ed, input bit push);
        exp_t x;
        for (int k = 0; k < 40 && !bus.reqReady; k++) tick();
        bus.reqValid = 1'b1;
        bus.reqWrite = w;
        bus.reqAddr  = a;
        bus.reqData  = d;
        x.cyc  = cyc + lat;
        x.err  = e;
        x.data = ed;
        if (push) sb.push_back(x);
        tick();
        bus.reqValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.respValid, bus.respErr, bus.dataLoad, bus.dataWrite, bus.sharedReq} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {bus.respValid, bus.respErr, bus.dataLoad, bus.dataWrite, bus.sharedReq});
        end
        vectors++;
        if (bus.respData !== 16'h0 || bus.dataADDR !== 16'h0 || bus.dataIN !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_data: respData=%h dataADDR=%h dataIN=%h, required 0",
                     bus.respData, bus.dataADDR, bus.dataIN);
        end
        vectors++;
        if (bus.reqReady !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, required 1", bus.reqReady);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_private();
        int w0;
        w0 = n_write;
        send(1'b1, 16'h0012, 16'hBEEF, 2, 1'b0, 16'h0000, 1'b1);
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL priv_store_drain: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
        vectors++;
        if (n_write - w0 !== 1) begin
            miscompares++;
            $display("FAIL priv_store_pulses: got %0d, required 1", n_write - w0);
        end
        vectors++;
        if (last_waddr !== 16'h0012 || last_wdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL priv_store_bus: addr=%h data=%h, required 0012 BEEF",
                     last_waddr, last_wdata);
        end
        send(1'b0, 16'h0012, 16'h0000, 2, 1'b0, 16'hBEEF, 1'b1);
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL priv_load_drain: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_shared();
        int l0;
        l0 = n_load;
        bus.sharedGrant = 1'b0;
        send(1'b0, 16'h0105, 16'h0000, 5, 1'b0, 16'h1234, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) bus.sharedGrant = 1'b1;
            vectors++;
            if (bus.sharedReq !== 1'b1) begin
                miscompares++;
                $display("FAIL shr_req_wait c%0d: got %b, required 1", c, bus.sharedReq);
            end
            if (c < 3) tick();
        end
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        bus.sharedGrant = 1'b0;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL shr_drain: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
        vectors++;
        if (n_load - l0 !== 1) begin
            miscompares++;
            $display("FAIL shr_load_pulses: got %0d, required 1", n_load - l0);
        end
        vectors++;
        if (last_shr !== 1'b1) begin
            miscompares++;
            $display("FAIL shr_req_access: got %b, required 1", last_shr);
        end
        vectors++;
        if (bus.sharedReq !== 1'b0) begin
            miscompares++;
            $display("FAIL shr_req_resp: got %b, required 0", bus.sharedReq);
        end
    endtask

    task automatic test_timeout();
        int w0;
        w0 = n_write;
        bus.sharedGrant = 1'b0;
        send(1'b1, 16'h01FF, 16'hAAAA, 16, 1'b1, 16'h0000, 1'b1);
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL tmo_drain: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
        vectors++;
        if (n_write - w0 !== 0) begin
            miscompares++;
            $display("FAIL tmo_no_write: got %0d pulses, required 0", n_write - w0);
        end
        vectors++;
        if (bus.sharedReq !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_req_resp: got %b, required 0", bus.sharedReq);
        end
        w0 = n_write;
        send(1'b1, 16'h01A0, 16'h5A5A, 17, 1'b0, 16'h0000, 1'b1);
        repeat (14) tick();
        bus.sharedGrant = 1'b1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        bus.sharedGrant = 1'b0;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL tmo_last_drain: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
        vectors++;
        if (n_write - w0 !== 1 || last_wdata !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL tmo_last_grant: pulses=%0d data=%h, required 1 5A5A",
                     n_write - w0, last_wdata);
        end
    endtask

    task automatic test_out_of_range();
        int s0;
        s0 = n_load + n_write;
        send(1'b0, 16'h0200, 16'h0000, 1, 1'b1, 16'h0000, 1'b1);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL oor_drain: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
        tick();
        vectors++;
        if (bus.reqReady !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_ready: got %b, required 1", bus.reqReady);
        end
        tick();
        vectors++;
        if (n_load + n_write - s0 !== 0) begin
            miscompares++;
            $display("FAIL oor_no_strobe: got %0d, required 0", n_load + n_write - s0);
        end
    endtask

    task automatic test_back_to_back();
        int   prev;
        int   acc;
        int   busy;
        int   o0;
        logic wr;
        exp_t x;
        prev = 0;
        o0   = n_overlap;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 40 && !bus.reqReady; k++) tick();
            wr = (i % 2 == 0);
            bus.reqValid = 1'b1;
            bus.reqWrite = wr;
            bus.reqAddr  = 16'h0030 + 16'(i / 2);
            bus.reqData  = (i < 2) ? 16'h1111 : 16'h2222;
            x.cyc  = cyc + 2;
            x.err  = 1'b0;
            x.data = wr ? 16'h0000 : ((i < 2) ? 16'h1111 : 16'h2222);
            sb.push_back(x);
            tick();
            acc = cyc;
            if (i == 3) bus.reqValid = 1'b0;
            vectors++;
            if (bus.reqReady !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_accept%0d: reqReady=%b, required 0", i, bus.reqReady);
            end
            vectors++;
            if (bus.dataWrite !== wr || bus.dataLoad !== ~wr) begin
                miscompares++;
                $display("FAIL b2b_strobe%0d: load=%b write=%b, required %b %b",
                         i, bus.dataLoad, bus.dataWrite, ~wr, wr);
            end
            busy = 0;
            for (int k = 0; k < 10 && !bus.reqReady; k++) begin
                busy++;
                tick();
            end
            vectors++;
            if (busy !== 2) begin
                miscompares++;
                $display("FAIL b2b_busy%0d: got %0d cycles, required 2", i, busy);
            end
            if (i > 0) begin
                vectors++;
                if (acc - prev !== 3) begin
                    miscompares++;
                    $display("FAIL b2b_spacing%0d: got %0d, required 3", i, acc - prev);
                end
            end
            prev = acc;
        end
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: %0d outstanding, required 0", sb.size());
            sb.delete();
        end
        vectors++;
        if (n_overlap - o0 !== 0) begin
            miscompares++;
            $display("FAIL b2b_overlap: got %0d, required 0", n_overlap - o0);
        end
    endtask

    task automatic test_reset_mid();
        int r0;
        for (int p = 0; p < 2; p++) begin
            bus.sharedGrant = 1'b0;
            if (p == 0) begin
                send(1'b0, 16'h0110, 16'h0000, 0, 1'b0, 16'h0000, 1'b0);
                tick();
            end else begin
                send(1'b0, 16'h0040, 16'h0000, 0, 1'b0, 16'h0000, 1'b0);
                vectors++;
                if (bus.dataLoad !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rmid_in_access: dataLoad=%b, required 1", bus.dataLoad);
                end
            end
            r0  = n_resp;
            rst = 1'b1;
            tick();
            vectors++;
            if ({bus.dataLoad, bus.dataWrite, bus.sharedReq, bus.respValid} !== 4'b0 ||
                bus.reqReady !== 1'b1) begin
                miscompares++;
                $display("FAIL rmid%0d_abort: ld/wr/shr/rv=%b ready=%b, required 0000 1", p,
                         {bus.dataLoad, bus.dataWrite, bus.sharedReq, bus.respValid}, bus.reqReady);
            end
            rst = 1'b0;
            tick();
            vectors++;
            if (bus.reqReady !== 1'b1) begin
                miscompares++;
                $display("FAIL rmid%0d_ready: got %b, required 1", p, bus.reqReady);
            end
            repeat (4) tick();
            vectors++;
            if (n_resp - r0 !== 0) begin
                miscompares++;
                $display("FAIL rmid%0d_no_resp: got %0d, required 0", p, n_resp - r0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h105]    = 16'h1234;
        bus.reqValid    = 1'b0;
        bus.reqWrite    = 1'b0;
        bus.reqAddr     = '0;
        bus.reqData     = '0;
        bus.dataOUT     = '0;
        bus.sharedGrant = 1'b0;
        test_reset();
        test_private();
        test_shared();
        test_timeout();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
